// File: rtl/muldiv_pkg.sv
// ============================================================================
// muldiv_pkg : shared constants and FSM state type for the RV32M mul/div unit
// Revision   : 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int ITERS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_iter.sv
// ============================================================================
// muldiv_iter : one combinational shift-add (multiply) or restoring
//               shift-subtract (divide) step on a 2*WIDTH accumulator
// Revision    : 1.0
// ============================================================================
`default_nettype none

module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] sub_diff;
  logic             sub_ok;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend bits / quotient bits}.
  always_comb begin
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    sub_ok   = acc[2*WIDTH-1:WIDTH-1] >= {1'b0, opnd};
    sub_diff = acc[2*WIDTH-2:WIDTH-1] - opnd;
    if (is_div) begin
      if (sub_ok) acc_next = {sub_diff, acc[WIDTH-2:0], 1'b1};
      else        acc_next = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {add_sum, acc[WIDTH-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : iterative RV32M multiply/divide unit feeding the RF write port
//               Define MULDIV_FAST_MUL_EN for single-cycle multiplies.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [4:0]       rd_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_out,
  output logic             we
);

  state_t             state;
  logic [4:0]         count;
  logic [2:0]         fn_r;
  logic               neg_r;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd_r;
  logic [2*WIDTH-1:0] acc_nx;

  logic             is_div, a_sgn, b_sgn, a_neg, b_neg, neg_in;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, div_ovf, take_fast;
  logic [WIDTH-1:0] fast_res;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   div_sel, div_fix, calc_res;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*WIDTH+1:0] fast_prod;
`endif

  always_comb begin
    is_div   = funct3[2];
    a_sgn    = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
               (funct3 == F3_DIV) || (funct3 == F3_REM);
    b_sgn    = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
               (funct3 == F3_DIV) || (funct3 == F3_REM);
    a_neg    = a_sgn & op_a[WIDTH-1];
    b_neg    = b_sgn & op_b[WIDTH-1];
    a_mag    = a_neg ? (~op_a + 1'b1) : op_a;
    b_mag    = b_neg ? (~op_b + 1'b1) : op_b;
    // Remainder follows the dividend's sign; everything else the sign product.
    neg_in   = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = is_div && (op_b == {WIDTH{1'b0}});
    div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
               (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b == {WIDTH{1'b1}});
    if (div_zero)     fast_res = funct3[1] ? op_a : {WIDTH{1'b1}};
    else              fast_res = funct3[1] ? {WIDTH{1'b0}} : op_a;
`ifdef MULDIV_FAST_MUL_EN
    fast_prod = $signed({a_sgn & op_a[WIDTH-1], op_a}) * $signed({b_sgn & op_b[WIDTH-1], op_b});
    take_fast = div_zero || div_ovf || !is_div;
    if (!is_div) begin
      fast_res = (funct3 == F3_MUL) ? fast_prod[WIDTH-1:0] : fast_prod[2*WIDTH-1:WIDTH];
    end
`else
    take_fast = div_zero || div_ovf;
`endif
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div   (fn_r[2]),
    .acc      (acc),
    .opnd     (opnd_r),
    .acc_next (acc_nx)
  );

  always_comb begin
    prod_fix = neg_r ? (~acc_nx + 1'b1) : acc_nx;
    div_sel  = fn_r[1] ? acc_nx[2*WIDTH-1:WIDTH] : acc_nx[WIDTH-1:0];
    div_fix  = neg_r ? (~div_sel + 1'b1) : div_sel;
    if (fn_r[2])              calc_res = div_fix;
    else if (fn_r == F3_MUL)  calc_res = prod_fix[WIDTH-1:0];
    else                      calc_res = prod_fix[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= 5'd0;
      fn_r   <= 3'd0;
      neg_r  <= 1'b0;
      acc    <= '0;
      opnd_r <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      we     <= 1'b0;
      result <= '0;
      rd_out <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            fn_r   <= funct3;
            neg_r  <= neg_in;
            rd_out <= rd_in;
            count  <= 5'd0;
            busy   <= 1'b1;
            if (take_fast) begin
              state  <= DONE;
              done   <= 1'b1;
              we     <= (rd_in != 5'd0);
              result <= fast_res;
            end else begin
              state  <= CALC;
              opnd_r <= is_div ? b_mag : a_mag;
              acc    <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
            end
          end
        end
        CALC: begin
          acc   <= acc_nx;
          count <= count + 5'd1;
          if (count == 5'(ITERS - 1)) begin
            state  <= DONE;
            done   <= 1'b1;
            we     <= (rd_out != 5'd0);
            result <= calc_res;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          we    <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit : directed scoreboard bench for muldiv_unit
// Revision       : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT  = 33;
  localparam int FAST_LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        busy, done, we;
  logic [31:0] result;
  logic [4:0]  rd_out;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out),
    .we     (we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble inputs after acceptance, optionally pulse start
  // while busy at cycle poke_at, then compare the completion to the scoreboard.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat, input int poke_at);
    exp_t e;
    int   k;
    bit   got;
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
    e.res = exp_res; e.rd = rd; e.we = (rd != 5'd0); e.lat = exp_lat;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom);
    k = 0; got = 1'b0;
    while (!got && k < 100) begin
      @(negedge clk); k++;
      if (k == 1) chk({tag, " busy"}, 32'(busy), 32'd1);
      if (k == poke_at) begin
        start = 1'b1; funct3 = F3_DIVU; op_a = 32'd99; op_b = 32'd9; rd_in = 5'd7;
      end else begin
        start = 1'b0;
      end
      if (done) got = 1'b1;
    end
    start = 1'b0;
    chk({tag, " done_seen"}, 32'(got), 32'd1);
    e = sb.pop_front();
    chk({tag, " latency"}, 32'(k), 32'(e.lat));
    chk({tag, " result"}, result, e.res);
    chk({tag, " rd_out"}, 32'(rd_out), 32'(e.rd));
    chk({tag, " we"}, 32'(we), 32'(e.we));
    @(negedge clk);
    chk({tag, " done_pulse"}, 32'(done), 32'd0);
    chk({tag, " held"}, result, e.res);
    chk({tag, " busy_clr"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n_done;
    #12;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst we", 32'(we), 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst rd_out", 32'(rd_out), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("MUL", F3_MUL, 32'd7, 32'd6, 5'd5, 32'd42, MUL_LAT, 0);
    run_op("MUL_neg", F3_MUL, 32'hFFFF_FFFD, 32'd5, 5'd9, 32'hFFFF_FFF1, MUL_LAT, 0);
    run_op("MULH", F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000, MUL_LAT, 0);
    run_op("MULHU", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, MUL_LAT, 0);
    run_op("MULHSU", F3_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'hFFFF_FFFF, MUL_LAT, 0);
    run_op("DIV", F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, DIV_LAT, 0);
    run_op("REM", F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, DIV_LAT, 0);
    run_op("DIVU", F3_DIVU, 32'd100, 32'd7, 5'd12, 32'd14, DIV_LAT, 0);
    run_op("REMU", F3_REMU, 32'd100, 32'd7, 5'd13, 32'd2, DIV_LAT, 0);
    run_op("DIVU_by0", F3_DIVU, 32'd5, 32'd0, 5'd14, 32'hFFFF_FFFF, FAST_LAT, 0);
    run_op("REM_by0", F3_REM, 32'd5, 32'd0, 5'd15, 32'd5, FAST_LAT, 0);
    run_op("DIV_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, FAST_LAT, 0);
    run_op("REM_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0, FAST_LAT, 0);
    run_op("DIV_rd0", F3_DIV, 32'd10, 32'd3, 5'd0, 32'd3, DIV_LAT, 5);

    // Abort an in-flight divide with reset at CALC cycle 10.
    @(negedge clk);
    start = 1'b1; funct3 = F3_DIVU; op_a = 32'd1000; op_b = 32'd7; rd_in = 5'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0; #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort we", 32'(we), 32'd0);
    chk("abort result", result, 32'd0);
    chk("abort rd_out", 32'(rd_out), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("abort no_done", 32'(n_done), 32'd0);
    run_op("DIVU_after_rst", F3_DIVU, 32'd9, 32'd3, 5'd6, 32'd3, DIV_LAT, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit sitting directly upstream of the register file write port. Accepts two 32-bit operands (the register file's two read outputs), a funct3 opcode and a destination index, computes over multiple cycles, and presents result, destination index and write-enable in the format the register file write port consumes. One operation is in flight at a time; the core stalls on `busy`.

## Interface
- `WIDTH`, 32, operand/result width (only 32 supported)
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request; accepted only when `busy`=0
- `funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `op_a`  in  32  rs1 value (dividend / multiplicand)
- `op_b`  in  32  rs2 value (divisor / multiplier)
- `rd_in`  in  5  destination register index
- `busy`  out  1  high from the cycle after acceptance through the done cycle
- `done`  out  1  one-cycle pulse, result valid
- `result`  out  32  computed value; held until next acceptance
- `rd_out`  out  5  latched `rd_in`
- `we`  out  1  `done && (rd_out != 0)`; drives the register file write enable

## Operation
- States: IDLE, CALC, DONE.
- IDLE: on `start`, latch `funct3`, `op_a`, `op_b`, `rd_in`; later input changes are ignored. Go to CALC, counter = 0; special cases and (with macro) multiplies go straight to DONE.
- CALC: one iteration per cycle, counter 0..31; after iteration 31 go to DONE.
- DONE: `done`=1, `we` per rule above; next cycle IDLE. `start` in DONE is ignored (not queued).
- Multiply: take magnitudes per signedness (MUL/MULH both signed, MULHSU rs1 signed/rs2 unsigned, MULHU unsigned); 32-step shift-add into a 64-bit accumulator; negate product if signs differ. MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- Divide: magnitudes for DIV/REM; 32-step restoring shift-subtract. Quotient negated if signs differ; remainder takes dividend's sign.
- Special cases (detected at acceptance, zero CALC cycles): divisor 0 → DIV/DIVU = 0xFFFFFFFF, REM/REMU = op_a; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0.
- `start` while `busy`=1: ignored, no state change.

## Timing
- Reset (async, any state): state IDLE, `busy`=0, `done`=0, `we`=0, `result`=0, `rd_out`=0, counter 0. Reset mid-CALC aborts; no `done` issued.
- Accepted at edge N: `busy` high from N+1. Normal path: CALC N+1..N+32, `done` in cycle N+33 (latency 33). Fast path: `done` in cycle N+1.
- `result`/`rd_out` registered, valid when `done`=1, stable until next acceptance.
- Back-to-back: earliest next acceptance is the edge ending the first IDLE cycle after DONE.

## Configuration
- `MULDIV_FAST_MUL_EN` defined: all four multiplies use a single-cycle 33×33 signed product computed at acceptance; IDLE→DONE, latency 1. Division unchanged.
- Not defined: multiplies use the 32-iteration shift-add path, latency 33. Results bit-identical in both builds.

## Structure
- Package `muldiv_pkg`: funct3 localparams (`F3_MUL`..`F3_REMU`), state enum (IDLE/CALC/DONE), iteration count constant 32.
- One sub-module `muldiv_iter`: combinational single-step datapath (shift-add step and shift-subtract step on 64-bit accumulator); `muldiv_unit` owns FSM, counter, sign fix-up, special cases, output registers.

## Test plan
- MUL 7 × 6, rd=5 → `done` at N+33 (N+1 with macro), `result`=42, `rd_out`=5, `we`=1.
- MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000; MULHU same operands → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV -7 / 2 → 0xFFFFFFFD; REM -7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2; each latency 33.
- DIVU 5 / 0 → 0xFFFFFFFF, REM 5 / 0 → 5, DIV 0x80000000 / -1 → 0x80000000; all with `done` at N+1.
- rd=0, DIV 10/3 → `done`=1, `result`=3, `we`=0; `start` pulsed mid-CALC with different operands → ignored, result still 3.
- Assert `rst_n`=0 at CALC cycle 10 → outputs 0 immediately, no `done`; new DIVU 9/3 after release → 3 at latency 33.
